// File: rtl/dram_wb_pkg.sv
// rtl/dram_wb_pkg.sv - line geometry, FSM states, buffer type and word helpers for wb_line_master
package dram_wb_pkg;

  localparam int LINE_BITS      = 256;
  localparam int LINE_LSB       = $clog2(LINE_BITS / 8);
  localparam int WORDS_PER_LINE = LINE_BITS / 32;
  localparam int WIDX_W         = LINE_LSB - 2;
  localparam int TAG_W          = 32 - LINE_LSB;

  typedef enum logic [2:0] {
    WBM_IDLE  = 3'd0,
    WBM_FILL  = 3'd1,
    WBM_MERGE = 3'd2,
    WBM_WRITE = 3'd3,
    WBM_RESP  = 3'd4
  } wbm_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] data;
  } line_t;

  // Byte-granular overlay of one 32-bit word; unselected bytes keep the line contents.
  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0] line,
    input logic [WIDX_W-1:0]    idx,
    input logic [31:0]          wdata,
    input logic [3:0]           wstrb
  );
    logic [LINE_BITS-1:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[int'(idx)*32 + b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] get_word(
    input logic [LINE_BITS-1:0] line,
    input logic [WIDX_W-1:0]    idx
  );
    return line[int'(idx)*32 +: 32];
  endfunction

endpackage

// File: rtl/wb_line_master.sv
// rtl/wb_line_master.sv - Wishbone classic initiator with a one-line read buffer and write-through RMW
module wb_line_master
  import dram_wb_pkg::*;
#(
  parameter int WORD_SIZE  = 256,
  parameter int ADDR_SHIFT = 7
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 init_i,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [31:0]          addr_o,
  output logic [WORD_SIZE-1:0] data_o,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic                 ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  wbm_state_t           state;
  line_t                line_q;
  logic                 flush_pend;
  logic                 rq_we;
  logic [TAG_W-1:0]     rq_tag;
  logic [WIDX_W-1:0]    rq_idx;
  logic [31:0]          rq_wdata;
  logic [3:0]           rq_wstrb;

  logic [TAG_W-1:0]     acc_tag;
  logic [WIDX_W-1:0]    acc_idx;
  logic                 acc_hit;
  logic [31:0]          acc_line_addr;
  logic [LINE_BITS-1:0] merged;
  logic                 unused_addr_bits;

  assign acc_tag          = req_addr_i[31:LINE_LSB];
  assign acc_idx          = req_addr_i[LINE_LSB-1:2];
  assign acc_hit          = line_q.valid && (line_q.tag == acc_tag);
  // Bits shifted past bit 31 fall off, matching the slave's line decode.
  assign acc_line_addr    = {{LINE_LSB{1'b0}}, acc_tag} << ADDR_SHIFT;
  assign merged           = merge_word(line_q.data, rq_idx, rq_wdata, rq_wstrb);
  assign unused_addr_bits = ^req_addr_i[1:0];

  assign req_ready_o = (state == WBM_IDLE) && init_i && !flush_i && !flush_pend;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WBM_IDLE;
      line_q      <= '0;
      flush_pend  <= 1'b0;
      rq_we       <= 1'b0;
      rq_tag      <= '0;
      rq_idx      <= '0;
      rq_wdata    <= '0;
      rq_wstrb    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
    end else begin
      if (flush_i && state != WBM_IDLE) flush_pend <= 1'b1;

      case (state)
        WBM_IDLE: begin
          if (flush_i || flush_pend) begin
            line_q.valid <= 1'b0;
            flush_pend   <= 1'b0;
          end else if (req_valid_i && req_ready_o) begin
            rq_we    <= req_we_i;
            rq_tag   <= acc_tag;
            rq_idx   <= acc_idx;
            rq_wdata <= req_wdata_i;
            rq_wstrb <= req_wstrb_i;
            addr_o   <= acc_line_addr;
            if (acc_hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
            else         miss_cnt_o <= miss_cnt_o + 32'd1;
            if (acc_hit && !req_we_i) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= get_word(line_q.data, acc_idx);
              state       <= WBM_RESP;
            end else if (acc_hit) begin
              state <= WBM_MERGE;
            end else begin
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= 1'b0;
              state <= WBM_FILL;
            end
          end
        end

        WBM_FILL: begin
          if (ack_i) begin
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            line_q <= {1'b1, rq_tag, data_i};
            if (rq_we) begin
              state <= WBM_MERGE;
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= get_word(data_i, rq_idx);
              state       <= WBM_RESP;
            end
          end
        end

        // Bus is idle here, which also provides the gap between FILL and WRITE.
        WBM_MERGE: begin
          line_q.data <= merged;
          data_o      <= merged;
          cyc_o       <= 1'b1;
          stb_o       <= 1'b1;
          we_o        <= 1'b1;
          state       <= WBM_WRITE;
        end

        WBM_WRITE: begin
          if (ack_i) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            state       <= WBM_RESP;
          end
        end

        WBM_RESP: begin
          rsp_valid_o <= 1'b0;
          state       <= WBM_IDLE;
        end

        default: state <= WBM_IDLE;
      endcase
    end
  end

endmodule
